// File: rtl/rect_sum_calc_pkg.sv
// rect_sum_calc_pkg: corner ordering and per-corner sign table for integral-image rectangle sums
package rect_sum_calc_pkg;
  typedef enum logic [1:0] {TL, TR, BR, BL} corner_t;
  localparam logic [3:0] SIGN_NEG = 4'b1010;
endpackage

// File: rtl/fifo.sv
// fifo: power-of-two circular FIFO with show-ahead read and zero-filled preload entries
module fifo #(
  parameter int W_DATA = 8,
  parameter int DEPTH = 4,
  parameter int PRELOAD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [W_DATA-1:0] push_data,
  input  logic              pop,
  output logic [W_DATA-1:0] pop_data
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W_DATA-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  assign pop_data = mem[rd];
  // storage and pointers; PRELOAD entries start as zeros already queued
  always_ff @(posedge clk)
    if (rst) begin
      wr <= AW'(PRELOAD);
      rd <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr] <= push_data;
        wr <= wr + AW'(1);
      end
      if (pop) rd <= rd + AW'(1);
    end
endmodule

// File: rtl/rect_sum_calc.sv
// rect_sum_calc: issues corner reads to an integral image and folds the four responses into a rectangle sum
module rect_sum_calc
  import rect_sum_calc_pkg::*;
#(
  parameter int W_ADDR = 10,
  parameter int W_II = 18,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              addr_valid,
  output logic              addr_ready,
  input  logic [W_ADDR-1:0] addr_data,
  input  logic              addr_eot,
  output logic              mem_addr_valid,
  input  logic              mem_addr_ready,
  output logic [W_ADDR-1:0] mem_addr_data,
  input  logic              mem_data_valid,
  output logic              mem_data_ready,
  input  logic [W_II-1:0]   mem_data,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [W_II-1:0]   sum_data,
  output logic              err
);
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  logic [OW-1:0] outst;
  logic credit_ok, req_fire, rsp_fire, tag, last;
  corner_t idx;
  logic [W_II-1:0] acc, val;
  assign credit_ok = outst < OW'(MAX_OUTSTANDING);
  assign mem_addr_valid = addr_valid & credit_ok;
  assign mem_addr_data = addr_data;
  assign addr_ready = mem_addr_ready & credit_ok;
  assign req_fire = mem_addr_valid & mem_addr_ready;
  assign last = idx == BL;
  assign mem_data_ready = !(sum_valid && !sum_ready && last);
  assign rsp_fire = mem_data_valid & mem_data_ready;
  fifo #(.W_DATA(1), .DEPTH(MAX_OUTSTANDING), .PRELOAD(0)) u_tag (
    .clk(clk),
    .rst(rst),
    .push(req_fire),
    .push_data(addr_eot),
    .pop(rsp_fire),
    .pop_data(tag)
  );
  // signed corner contribution; TL starts a fresh accumulation
  always_comb val = (idx == TL ? '0 : acc) + (SIGN_NEG[idx] ? -mem_data : mem_data);
  // reads in flight, gating new requests
  always_ff @(posedge clk)
    if (rst) outst <= '0;
    else outst <= outst + OW'(req_fire) - OW'(rsp_fire);
  // corner tracking, accumulation and eot-tag consistency; any eot tag realigns to TL
  always_ff @(posedge clk)
    if (rst) begin
      idx <= TL;
      acc <= '0;
      err <= 1'b0;
    end else if (rsp_fire) begin
      idx <= tag ? TL : corner_t'(idx + 2'd1);
      acc <= last ? '0 : val;
      err <= err | (tag != last);
    end
  // output register, held until taken; a new BL result may replace a sum taken this cycle
  always_ff @(posedge clk)
    if (rst) begin
      sum_valid <= 1'b0;
      sum_data <= '0;
    end else if (rsp_fire && last) begin
      sum_valid <= 1'b1;
      sum_data <= val;
    end else if (sum_ready) sum_valid <= 1'b0;
endmodule

// File: tb/tb_rect_sum_calc.sv
// tb_rect_sum_calc: cycle-stepped memory model and sum scoreboard around rect_sum_calc
module tb_rect_sum_calc;
  typedef struct {logic [17:0] d; logic eot; int rc;} rsp_t;
  logic clk = 0, rst = 1;
  logic addr_valid = 0, addr_ready, addr_eot = 0;
  logic [9:0] addr_data = 0, mem_addr_data;
  logic mem_addr_valid, mem_addr_ready = 1;
  logic mem_data_valid = 0, mem_data_ready;
  logic [17:0] mem_data = 0, sum_data;
  logic sum_valid, sum_ready = 1, err;
  logic [17:0] img [1024];
  logic [10:0] aq [$];
  rsp_t pend [$];
  logic [17:0] sb [$];
  logic [9:0] na = 0, m_addr = 0;
  logic m_eot = 0, f_rst = 1, f_req = 0, f_mreq = 0, f_rsp = 0, f_sum = 0;
  logic a_en = 1, m_en = 1, ar_rand = 0, lat_rand = 0, sv_m = 0, err_m = 0;
  int sr_mode = 1, lat = 2, cyc = 0, idx_m = 0, out_m = 0, rsp_cnt = 0;
  int n_chk = 0, n_fail = 0;

  rect_sum_calc dut (
    .clk(clk), .rst(rst),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .addr_data(addr_data), .addr_eot(addr_eot),
    .mem_addr_valid(mem_addr_valid), .mem_addr_ready(mem_addr_ready), .mem_addr_data(mem_addr_data),
    .mem_data_valid(mem_data_valid), .mem_data_ready(mem_data_ready), .mem_data(mem_data),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_data(sum_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    rsp_t r;
    @(negedge clk);
    cyc++;
    if (!rst && !f_rst) begin
      if (f_rsp && pend.size() > 0) begin
        r = pend.pop_front();
        err_m = err_m | (r.eot != (idx_m == 3));
        if (idx_m == 3) sv_m = 1;
        else if (f_sum) sv_m = 0;
        idx_m = r.eot ? 0 : (idx_m + 1) % 4;
        rsp_cnt++;
      end else if (f_sum) sv_m = 0;
      if (f_sum && sb.size() > 0) void'(sb.pop_front());
      if (f_mreq) pend.push_back('{img[m_addr], m_eot, cyc - 1 + lat});
      if (f_req && aq.size() > 0) void'(aq.pop_front());
      out_m = out_m + int'(f_req) - int'(f_rsp);
    end
    if (lat_rand) lat = $urandom_range(1, 3);
    addr_valid = a_en && aq.size() > 0;
    {addr_eot, addr_data} = aq.size() > 0 ? aq[0] : 11'd0;
    mem_addr_ready = ar_rand ? 1'($urandom % 2) : 1'b1;
    mem_data_valid = m_en && pend.size() > 0 && pend[0].rc <= cyc;
    mem_data = pend.size() > 0 ? pend[0].d : 18'd0;
    sum_ready = sr_mode == 2 ? 1'($urandom % 2) : sr_mode == 1;
    #1;
    f_rst = rst;
    f_req = addr_valid && addr_ready;
    f_mreq = mem_addr_valid && mem_addr_ready;
    f_rsp = mem_data_valid && mem_data_ready;
    f_sum = sum_valid && sum_ready;
    m_addr = mem_addr_data;
    m_eot = addr_eot;
    if (!rst) begin
      chk("addr_ready", addr_ready, mem_addr_ready && out_m < 4);
      chk("mem_addr_valid", mem_addr_valid, addr_valid && out_m < 4);
      if (addr_valid) chk("mem_addr_data", mem_addr_data, addr_data);
      chk("mem_data_ready", mem_data_ready, !(sv_m && !sum_ready && idx_m == 3));
      chk("sum_valid", sum_valid, sv_m);
      chk("err", err, err_m);
      if (sum_valid && sb.size() > 0) chk("sum_data", sum_data, sb[0]);
      else if (sum_valid) chk("sum_spurious", sb.size(), 1);
    end
  endtask

  task automatic rect(input logic [17:0] tl, tr, br, bl);
    logic [17:0] v [4];
    logic [17:0] e;
    v = '{tl, tr, br, bl};
    for (int i = 0; i < 4; i++) begin
      img[na] = v[i];
      aq.push_back({i == 3, na});
      na = na + 10'd1;
    end
    e = tl - tr + br - bl;
    sb.push_back(e);
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while ((aq.size() > 0 || pend.size() > 0 || sb.size() > 0 || sum_valid) && n < budget) begin
      step();
      n++;
    end
    chk("drain", aq.size() + pend.size() + sb.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1;
    aq.delete();
    pend.delete();
    sb.delete();
    step();
    step();
    chk("rst_sum_valid", sum_valid, 0);
    chk("rst_sum_data", sum_data, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_data_ready", mem_data_ready, 1);
    idx_m = 0;
    sv_m = 0;
    err_m = 0;
    out_m = 0;
    rst = 0;
    step();
    chk("rst_addr_ready", addr_ready, mem_addr_ready);
  endtask

  initial begin
    int n;
    do_reset();
    rect(100, 40, 300, 90);
    run_idle(100);
    chk("basic_err", err, 0);
    rect(5, 262140, 10, 0);
    run_idle(100);
    m_en = 0;
    rect(1, 2, 3, 4);
    rect(50, 10, 70, 20);
    repeat (12) step();
    chk("credit_accepted", 8 - aq.size(), 4);
    chk("credit_block", addr_ready, 0);
    chk("credit_hold", mem_addr_valid, 0);
    m_en = 1;
    run_idle(200);
    sr_mode = 0;
    rect(1000, 200, 3000, 500);
    rect(7, 3, 11, 2);
    repeat (20) step();
    chk("bl_stalled", pend.size(), 1);
    chk("bl_ready_low", mem_data_ready, 0);
    chk("sum_held", sum_valid, 1);
    sr_mode = 1;
    run_idle(100);
    chk("pre_err", err, 0);
    for (int i = 0; i < 3; i++) begin
      img[na] = 18'(i + 1);
      aq.push_back({i == 2, na});
      na = na + 10'd1;
    end
    run_idle(100);
    chk("err_set", err, 1);
    rect(400, 100, 900, 200);
    run_idle(100);
    chk("err_sticky", err, 1);
    rsp_cnt = 0;
    n = 0;
    rect(60, 6, 600, 66);
    while (rsp_cnt < 2 && n < 50) begin
      step();
      n++;
    end
    chk("mid_rect_responses", rsp_cnt, 2);
    do_reset();
    rect(123, 23, 456, 56);
    run_idle(100);
    chk("post_rst_err", err, 0);
    ar_rand = 1;
    lat_rand = 1;
    sr_mode = 2;
    for (int k = 0; k < 20; k++)
      rect(18'($urandom), 18'($urandom), 18'($urandom), 18'($urandom));
    run_idle(2000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rect_sum_calc.md
RECT_SUM_CALC -- requirements
Module: rect_sum_calc

Interface
REQ-001 Parameters SHALL be: W_ADDR, default 10, integral-image address width; W_II, default 18, integral-image value and sum width; MAX_OUTSTANDING, default 4, maximum memory reads in flight (power of two).
REQ-002 Port clk SHALL be an input of width 1, the system clock; all logic is on the rising edge.
REQ-003 Port rst SHALL be an input of width 1: synchronous, active-high reset.
REQ-004 Ports addr_valid (in, 1), addr_ready (out, 1), addr_data (in, W_ADDR) and addr_eot (in, 1) SHALL form the corner-address stream: 4 addresses per rectangle in order TL, TR, BR, BL, with eot on BL.
REQ-005 Ports mem_addr_valid (out, 1), mem_addr_ready (in, 1) and mem_addr_data (out, W_ADDR) SHALL form the integral-image read-request port.
REQ-006 Ports mem_data_valid (in, 1), mem_data_ready (out, 1) and mem_data (in, W_II) SHALL form the in-order read-response port, with latency of 1 or more cycles.
REQ-007 Ports sum_valid (out, 1), sum_ready (in, 1) and sum_data (out, W_II) SHALL carry the rectangle sum output.
REQ-008 Port err (out, 1) SHALL be a sticky protocol-error flag.

Function
REQ-009 A transfer on any valid/ready port SHALL occur only in a cycle where both valid and ready are high; data and eot are sampled in that cycle.
REQ-010 The block SHALL pass request addresses through combinationally: mem_addr_valid = addr_valid AND credit_ok; mem_addr_data = addr_data; addr_ready = mem_addr_ready AND credit_ok.
REQ-011 credit_ok SHALL be high iff outstanding < MAX_OUTSTANDING, where outstanding is +1 per request transfer and -1 per response transfer; a simultaneous +1/-1 leaves it unchanged.
REQ-012 On each request transfer, addr_eot SHALL be pushed into an internal tag FIFO of depth MAX_OUTSTANDING; on each response transfer, the FIFO SHALL be popped.
REQ-013 Response accumulation SHALL use a corner counter idx (0..3) and an accumulator acc (W_II bits, modulo 2^W_II).
- idx0: acc = mem_data
- idx1: acc = acc - mem_data
- idx2: acc = acc + mem_data
- idx3: result = acc - mem_data
REQ-014 On the idx3 response, the result SHALL be registered into sum_data, sum_valid SHALL be set, idx SHALL wrap to 0, and acc SHALL clear.
REQ-015 sum_valid SHALL stay high and sum_data SHALL stay stable until a sum transfer occurs.
REQ-016 mem_data_ready SHALL be low while sum_valid = 1 and sum_ready = 0 with idx = 3 pending, and high otherwise.
REQ-017 Because of REQ-016, the next rectangle's TL..BR responses SHALL still be accepted while a sum is waiting; only its BL response SHALL stall.
REQ-018 If sum_valid = 1 and sum_ready = 1 in the same cycle as an idx3 response, the old sum SHALL transfer and the new sum SHALL load with sum_valid remaining 1; this is a zero-bubble case.
REQ-019 Latency SHALL be 1 clock from the idx3 response transfer to sum_valid = 1.
REQ-020 If a popped eot tag is 1 while idx != 3, or 0 while idx = 3, err SHALL be set; idx SHALL then resynchronise to 0 after any tag = 1.
REQ-021 err SHALL stay set until reset.
REQ-022 Sums SHALL use wrap-around (modulo) arithmetic and SHALL NOT saturate; this is valid for integral images because the true sum is always at most 2^W_II - 1.

Reset
REQ-023 While rst = 1, the block SHALL hold: outstanding = 0, tag FIFO empty, idx = 0, acc = 0, sum_valid = 0, sum_data = 0, err = 0.
REQ-024 Reset asserted mid-rectangle SHALL discard partial sums and in-flight tags; responses arriving after reset SHALL be accepted only as new TL data.
REQ-025 The memory is reset in the same cycle as this block, so no stale responses arrive after reset.
REQ-026 addr_ready and mem_addr_valid SHALL follow REQ-010 from the first cycle after reset (credit_ok = 1).

Structure
REQ-027 The shared package SHALL hold the corner enum (TL, TR, BR, BL) and the sign table (+, -, +, -).
REQ-028 The tag FIFO SHALL be an instance of the existing fifo module: W_DATA = 1, DEPTH = MAX_OUTSTANDING, PRELOAD = 0.
REQ-029 No other sub-modules SHALL be used; the RTL target is about 150-250 lines.

Verification
REQ-030 Memory model with latency 2 returning TL = 100, TR = 40, BR = 300, BL = 90, addresses sent back-to-back -> sum_data = 270 one cycle after the BL response; err = 0.
REQ-031 Modulo case with W_II = 18: TL = 5, TR = 262140, BR = 10, BL = 0 -> sum_data = 19 (wrap).
REQ-032 sum_ready held low for 10 cycles while a second rectangle streams -> TL/TR/BR responses accepted, BL stalled, first sum held stable; both sums delivered in order when sum_ready rises.
REQ-033 mem_addr_ready = 1 with the memory never responding -> exactly MAX_OUTSTANDING = 4 requests accepted, then addr_ready = 0 until a response arrives.
REQ-034 eot asserted on the 3rd address -> err = 1 and stays set; the next correct 4-address group still yields the correct sum.
REQ-035 rst pulsed after 2 responses of a rectangle -> no sum_valid pulse; a following clean rectangle gives the correct sum.
